// File: rtl/matrix_store.sv
// matrix_store: slot-allocated matrix storage with streamed loads, registered reads, delete and occupancy.
// Ports: clk/rst (async active-high); wr_start/wr_rows/wr_cols open a load into the lowest free slot;
// wr_valid/wr_data/wr_ready stream row-major elements; wr_abort drops the load; wr_id/wr_done/wr_err report it;
// rd_en/rd_id/rd_row/rd_col -> rd_data/rd_valid/rd_err one cycle later; del_en/del_id free a slot;
// q_id -> q_rows/q_cols metadata; slot_valid/matrix_count/storage_full/busy report occupancy and state.
module matrix_store #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int SLOTS   = 8,
    localparam int DIM_W  = $clog2(MAX_DIM + 1),
    localparam int ID_W   = $clog2(SLOTS),
    localparam int CNT_W  = $clog2(SLOTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_start,
    input  logic [DIM_W-1:0]  wr_rows,
    input  logic [DIM_W-1:0]  wr_cols,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              wr_abort,
    output logic [ID_W-1:0]   wr_id,
    output logic              wr_done,
    output logic              wr_err,
    input  logic              rd_en,
    input  logic [ID_W-1:0]   rd_id,
    input  logic [DIM_W-1:0]  rd_row,
    input  logic [DIM_W-1:0]  rd_col,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              del_en,
    input  logic [ID_W-1:0]   del_id,
    input  logic [ID_W-1:0]   q_id,
    output logic [DIM_W-1:0]  q_rows,
    output logic [DIM_W-1:0]  q_cols,
    output logic [SLOTS-1:0]  slot_valid,
    output logic [CNT_W-1:0]  matrix_count,
    output logic              storage_full,
    output logic              busy
);
    localparam int SZ = MAX_DIM * MAX_DIM;
    localparam int AW = $clog2(SLOTS * SZ);
    localparam logic [DIM_W-1:0] MAXD = DIM_W'(MAX_DIM);

    typedef enum logic {IDLE, LOAD} state_t;
    state_t r_state, w_state_next;

    logic [ID_W-1:0]               r_id, w_free_id;
    logic [DIM_W-1:0]              r_rows, r_cols, r_row, r_col;
    logic [SLOTS-1:0]              r_valid;
    logic [SLOTS-1:0][DIM_W-1:0]   r_mrows, r_mcols;
    logic [CNT_W-1:0]              r_count;
    logic                          r_wr_done, r_wr_err, r_rd_valid, r_rd_err;
    logic [DATA_W-1:0]             r_rd_data;
    logic [DATA_W-1:0]             r_ram [SLOTS*SZ];
    logic                          w_load, w_start_ok, w_beat, w_col_end, w_last, w_del, w_rd_ok;
    logic [AW-1:0]                 w_wr_addr, w_rd_addr;

    always_comb begin
        w_free_id = '0;
        for (int i = SLOTS - 1; i >= 0; i--)
            if (!r_valid[i]) w_free_id = ID_W'(i);
    end

    assign w_load     = r_state == LOAD;
    // Full check uses registered count, so a same-cycle delete cannot make room for this start.
    assign w_start_ok = !w_load && wr_start && !storage_full &&
                        wr_rows != '0 && wr_rows <= MAXD && wr_cols != '0 && wr_cols <= MAXD;
    // Abort wins over a beat arriving in the same cycle.
    assign w_beat     = w_load && wr_valid && !wr_abort;
    assign w_col_end  = r_col == r_cols - 1'b1;
    assign w_last     = w_beat && w_col_end && r_row == r_rows - 1'b1;
    // The loading slot is never marked valid, so deleting it is naturally a no-op.
    assign w_del      = del_en && r_valid[del_id];
    assign w_rd_ok    = rd_en && r_valid[rd_id] && rd_row < r_mrows[rd_id] && rd_col < r_mcols[rd_id];
    assign w_wr_addr  = AW'(int'(r_id) * SZ + int'(r_row) * MAX_DIM + int'(r_col));
    assign w_rd_addr  = AW'(int'(rd_id) * SZ + int'(rd_row) * MAX_DIM + int'(rd_col));

    always_comb begin
        w_state_next = w_load ? ((wr_abort || w_last) ? IDLE : LOAD) : (w_start_ok ? LOAD : IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id       <= '0;
            r_rows     <= '0;
            r_cols     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_valid    <= '0;
            r_mrows    <= '0;
            r_mcols    <= '0;
            r_count    <= '0;
            r_wr_done  <= 1'b0;
            r_wr_err   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_start_ok) begin
                r_id   <= w_free_id;
                r_rows <= wr_rows;
                r_cols <= wr_cols;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_beat) begin
                r_col <= w_col_end ? '0 : r_col + 1'b1;
                r_row <= w_col_end ? r_row + 1'b1 : r_row;
            end
            if (w_del) begin
                r_valid[del_id] <= 1'b0;
                r_mrows[del_id] <= '0;
                r_mcols[del_id] <= '0;
            end
            if (w_last) begin
                r_valid[r_id] <= 1'b1;
                r_mrows[r_id] <= r_rows;
                r_mcols[r_id] <= r_cols;
            end
            r_count    <= r_count + CNT_W'(w_last) - CNT_W'(w_del);
            r_wr_done  <= w_last;
            r_wr_err   <= !w_load && wr_start && !w_start_ok;
            r_rd_valid <= w_rd_ok;
            r_rd_err   <= rd_en && !w_rd_ok;
            r_rd_data  <= w_rd_ok ? r_ram[w_rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_beat) r_ram[w_wr_addr] <= wr_data;
    end

    assign wr_ready     = w_load;
    assign busy         = w_load;
    assign wr_id        = r_id;
    assign wr_done      = r_wr_done;
    assign wr_err       = r_wr_err;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign rd_err       = r_rd_err;
    assign q_rows       = r_mrows[q_id];
    assign q_cols       = r_mcols[q_id];
    assign slot_valid   = r_valid;
    assign matrix_count = r_count;
    assign storage_full = r_count == CNT_W'(SLOTS);
endmodule

// File: tb/tb_matrix_store.sv
// tb_matrix_store: scoreboard bench for matrix_store loads, reads, deletes, rejects, abort and reset.
module tb_matrix_store;
    localparam int DW = 8, MD = 5, NS = 8, DIM_W = 3, ID_W = 3, CNT_W = 4;

    logic             clk = 1'b0, rst = 1'b1;
    logic             wr_start = 1'b0, wr_valid = 1'b0, wr_abort = 1'b0;
    logic [DIM_W-1:0] wr_rows = '0, wr_cols = '0;
    logic [DW-1:0]    wr_data = '0;
    logic             wr_ready, wr_done, wr_err;
    logic [ID_W-1:0]  wr_id;
    logic             rd_en = 1'b0;
    logic [ID_W-1:0]  rd_id = '0;
    logic [DIM_W-1:0] rd_row = '0, rd_col = '0;
    logic [DW-1:0]    rd_data;
    logic             rd_valid, rd_err;
    logic             del_en = 1'b0;
    logic [ID_W-1:0]  del_id = '0, q_id = '0;
    logic [DIM_W-1:0] q_rows, q_cols;
    logic [NS-1:0]    slot_valid;
    logic [CNT_W-1:0] matrix_count;
    logic             storage_full, busy;

    matrix_store #(.DATA_W(DW), .MAX_DIM(MD), .SLOTS(NS)) dut (
        .clk(clk), .rst(rst),
        .wr_start(wr_start), .wr_rows(wr_rows), .wr_cols(wr_cols),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_abort(wr_abort),
        .wr_id(wr_id), .wr_done(wr_done), .wr_err(wr_err),
        .rd_en(rd_en), .rd_id(rd_id), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .del_en(del_en), .del_id(del_id), .q_id(q_id), .q_rows(q_rows), .q_cols(q_cols),
        .slot_valid(slot_valid), .matrix_count(matrix_count),
        .storage_full(storage_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    typedef struct {
        bit          err;
        logic [7:0]  data;
    } rd_exp_t;
    rd_exp_t rq[$];

    bit         mvalid[NS];
    int         mrows[NS], mcols[NS];
    logic [7:0] mmem[NS][MD*MD];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < NS; i++) c += int'(mvalid[i]);
        return c;
    endfunction

    function automatic int free_id();
        for (int i = 0; i < NS; i++) if (!mvalid[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic rd_exp_t expect_rd(input int id, input int row, input int col);
        rd_exp_t e;
        e.err  = 1'b1;
        e.data = 8'h00;
        if (mvalid[id] && row < mrows[id] && col < mcols[id]) begin
            e.err  = 1'b0;
            e.data = mmem[id][row*MD+col];
        end
        return e;
    endfunction

    task automatic do_read(input int id, input int row, input int col);
        rq.push_back(expect_rd(id, row, col));
        rd_en  = 1'b1;
        rd_id  = ID_W'(id);
        rd_row = DIM_W'(row);
        rd_col = DIM_W'(col);
        tick();
        rd_en  = 1'b0;
    endtask

    task automatic do_del(input int id);
        del_en = 1'b1;
        del_id = ID_W'(id);
        tick();
        del_en = 1'b0;
        mvalid[id] = 1'b0;
        mrows[id]  = 0;
        mcols[id]  = 0;
        check("del_slot_valid", slot_valid[id], 0);
        check("del_count", matrix_count, mcount());
    endtask

    task automatic try_reject(input int rows, input int cols, input string tag);
        wr_start = 1'b1;
        wr_rows  = DIM_W'(rows);
        wr_cols  = DIM_W'(cols);
        tick();
        wr_start = 1'b0;
        check({tag, "_err"}, wr_err, 1);
        check({tag, "_busy"}, busy, 0);
        tick();
        check({tag, "_err_pulse"}, wr_err, 0);
    endtask

    // dslot >= 0 deletes that slot in the same cycle as the final beat.
    task automatic load_mat(input int rows, input int cols, input int base, input int dslot);
        int id = free_id();
        int n  = rows * cols;
        wr_start = 1'b1;
        wr_rows  = DIM_W'(rows);
        wr_cols  = DIM_W'(cols);
        tick();
        wr_start = 1'b0;
        check("ld_wr_id", wr_id, id);
        check("ld_busy", busy, 1);
        check("ld_wr_err", wr_err, 0);
        for (int k = 0; k < n; k++) begin
            check("ld_wr_ready", wr_ready, 1);
            wr_valid = 1'b1;
            wr_data  = DW'(base + k);
            if (k == n - 1 && dslot >= 0) begin
                del_en = 1'b1;
                del_id = ID_W'(dslot);
            end
            tick();
            wr_valid = 1'b0;
            del_en   = 1'b0;
            mmem[id][(k / cols) * MD + (k % cols)] = DW'(base + k);
            check("ld_wr_done", wr_done, k == n - 1);
        end
        mvalid[id] = 1'b1;
        mrows[id]  = rows;
        mcols[id]  = cols;
        if (dslot >= 0) begin
            mvalid[dslot] = 1'b0;
            mrows[dslot]  = 0;
            mcols[dslot]  = 0;
        end
        check("ld_slot_valid", slot_valid[id], 1);
        check("ld_busy_end", busy, 0);
        check("ld_count", matrix_count, mcount());
    endtask

    always @(negedge clk) begin
        if (!rst && (rd_valid || rd_err)) begin
            rd_exp_t e;
            if (rq.size() == 0) begin
                check("rd_unexpected", 1, 0);
            end else begin
                e = rq.pop_front();
                check("rd_err", rd_err, e.err);
                check("rd_valid", rd_valid, !e.err);
                check("rd_data", rd_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_exp_t e;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", matrix_count, 0);
        check("rst_slot_valid", slot_valid, 0);
        check("rst_full", storage_full, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_id", wr_id, 0);
        check("rst_q_rows", q_rows, 0);
        rst = 1'b0;
        tick();

        load_mat(2, 3, 1, -1);
        check("q_rows_2x3", q_rows, 2);
        check("q_cols_2x3", q_cols, 3);
        do_read(0, 1, 2);
        do_read(0, 0, 0);
        do_read(0, 1, 1);
        do_read(0, 2, 0);
        tick();

        try_reject(0, 3, "rows0");
        try_reject(6, 3, "rows6");
        try_reject(2, 0, "cols0");

        load_mat(2, 2, 8'h40, -1);
        do_read(1, 2, 0);
        do_read(1, 1, 1);

        e = expect_rd(1, 0, 1);
        rq.push_back(e);
        rd_en = 1'b1; rd_id = 3'd1; rd_row = 3'd0; rd_col = 3'd1;
        del_en = 1'b1; del_id = 3'd1;
        tick();
        rd_en = 1'b0; del_en = 1'b0;
        mvalid[1] = 1'b0; mrows[1] = 0; mcols[1] = 0;
        check("rddel_slot_valid", slot_valid[1], 0);
        check("rddel_count", matrix_count, 1);
        do_read(1, 0, 0);

        do_del(0);
        check("q_rows_deleted", q_rows, 0);
        wr_start = 1'b1; wr_rows = 3'd5; wr_cols = 3'd5;
        tick();
        wr_start = 1'b0;
        check("abort_wr_id", wr_id, 0);
        for (int k = 0; k < 10; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'hA0 + k);
            tick();
            check("abort_no_done", wr_done, 0);
        end
        wr_valid = 1'b1; wr_abort = 1'b1;
        tick();
        wr_valid = 1'b0; wr_abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", wr_ready, 0);
        check("abort_slot0", slot_valid[0], 0);
        check("abort_count", matrix_count, 0);
        tick();
        check("abort_done_late", wr_done, 0);
        do_read(0, 0, 0);

        wr_start = 1'b1; wr_rows = 3'd1; wr_cols = 3'd2;
        tick();
        check("dl_wr_id", wr_id, 0);
        del_en = 1'b1; del_id = 3'd0;
        wr_rows = 3'd0;
        tick();
        wr_start = 1'b0; del_en = 1'b0;
        check("ignored_start_err", wr_err, 0);
        check("dl_busy", busy, 1);
        check("dl_slot0", slot_valid[0], 0);
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'h70 + k);
            tick();
            mmem[0][k] = DW'(8'h70 + k);
            check("dl_done", wr_done, k == 1);
        end
        wr_valid = 1'b0;
        mvalid[0] = 1'b1; mrows[0] = 1; mcols[0] = 2;
        check("dl_slot0_commit", slot_valid[0], 1);
        do_read(0, 0, 1);

        for (int i = 1; i < NS; i++) load_mat(1, 1, 8'h80 + i, -1);
        check("full_flag", storage_full, 1);
        check("full_count", matrix_count, 8);
        try_reject(1, 1, "full");
        del_en = 1'b1; del_id = 3'd3;
        wr_start = 1'b1; wr_rows = 3'd1; wr_cols = 3'd1;
        tick();
        del_en = 1'b0; wr_start = 1'b0;
        mvalid[3] = 1'b0; mrows[3] = 0; mcols[3] = 0;
        check("full_del_err", wr_err, 1);
        check("full_del_busy", busy, 0);
        check("full_del_count", matrix_count, 7);
        check("full_del_flag", storage_full, 0);
        load_mat(2, 2, 8'h90, 6);
        check("commit_del_count", matrix_count, 7);
        do_read(3, 1, 0);
        do_read(6, 0, 0);
        do_read(7, 0, 0);
        tick();

        wr_start = 1'b1; wr_rows = 3'd3; wr_cols = 3'd3;
        tick();
        wr_start = 1'b0;
        check("rl_wr_id", wr_id, 6);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(8'hC0 + k);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        check("rl_busy", busy, 0);
        check("rl_ready", wr_ready, 0);
        check("rl_count", matrix_count, 0);
        check("rl_slot_valid", slot_valid, 0);
        check("rl_full", storage_full, 0);
        check("rl_wr_id0", wr_id, 0);
        check("rl_q_rows", q_rows, 0);
        wr_valid = 1'b0;
        for (int i = 0; i < NS; i++) begin
            mvalid[i] = 1'b0; mrows[i] = 0; mcols[i] = 0;
        end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < NS; i++) do_read(i, 0, 0);
        tick();
        tick();
        check("rd_queue_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
